// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lets two requesters share one combinational ALU,
// with a single registered response slot that can drain and refill each cycle.
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int FUNC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [FUNC_W-1:0] req0_func,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [FUNC_W-1:0] req1_func,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [FUNC_W-1:0] alu_func,
  input  logic [WIDTH-1:0]  alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              rsp_err
);

  localparam logic [FUNC_W-1:0] ALU_ADD  = FUNC_W'(0);
  localparam logic [FUNC_W-1:0] ALU_SUB  = FUNC_W'(1);
  localparam logic [FUNC_W-1:0] ALU_AND  = FUNC_W'(2);
  localparam logic [FUNC_W-1:0] ALU_OR   = FUNC_W'(3);
  localparam logic [FUNC_W-1:0] ALU_XOR  = FUNC_W'(4);
  localparam logic [FUNC_W-1:0] ALU_SLL  = FUNC_W'(5);
  localparam logic [FUNC_W-1:0] ALU_SRL  = FUNC_W'(6);
  localparam logic [FUNC_W-1:0] ALU_SRA  = FUNC_W'(7);
  localparam logic [FUNC_W-1:0] ALU_SLT  = FUNC_W'(8);
  localparam logic [FUNC_W-1:0] ALU_SLTU = FUNC_W'(9);

  function automatic logic alu_defined(input logic [FUNC_W-1:0] f);
    case (f)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic              r_valid;
  logic              r_id;
  logic              r_err;
  logic              r_last_grant;
  logic [WIDTH-1:0]  r_data;

  logic [1:0]        w_valid;
  logic [1:0]        w_ready;
  logic [WIDTH-1:0]  w_a    [2];
  logic [WIDTH-1:0]  w_b    [2];
  logic [FUNC_W-1:0] w_func [2];
  logic              w_slot_free;
  logic              w_accept;
  logic              w_sel;

  assign w_valid   = {req1_valid, req0_valid};
  assign w_a[0]    = req0_a;
  assign w_a[1]    = req1_a;
  assign w_b[0]    = req0_b;
  assign w_b[1]    = req1_b;
  assign w_func[0] = req0_func;
  assign w_func[1] = req1_func;

  // The slot may refill on the same edge the consumer takes the old response.
  assign w_slot_free = !r_valid || rsp_ready;

  // A requester wins if it is alone, or if the other one was served last.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_grant
      assign w_ready[gi] = w_slot_free && !rst && w_valid[gi] &&
                           (!w_valid[1-gi] || (r_last_grant != 1'(gi)));
    end
  endgenerate

  assign req0_ready = w_ready[0];
  assign req1_ready = w_ready[1];
  assign w_accept   = |w_ready;
  assign w_sel      = w_ready[1] ? 1'b1 : (w_ready[0] ? 1'b0 : ~r_last_grant);

  assign alu_a    = w_a[w_sel];
  assign alu_b    = w_b[w_sel];
  assign alu_func = w_func[w_sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_id         <= 1'b0;
      r_data       <= '0;
      r_err        <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_valid      <= 1'b1;
      r_id         <= w_sel;
      r_data       <= alu_result;
      r_err        <= !alu_defined(alu_func);
      r_last_grant <= w_sel;
    end else if (rsp_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_valid;
  assign rsp_id    = r_id;
  assign rsp_data  = r_data;
  assign rsp_err   = r_err;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 The block SHALL have parameter FUNC_W, default 4, ALU function-code width; codes are the ALU_* values from Defines.svh.
REQ-003 The block SHALL have one clock and a synchronous active-high reset: clk  input  1  rising-edge clock.
REQ-004 The block SHALL have rst  input  1  synchronous active-high reset.
REQ-005 The block SHALL have req0_valid  input  1  requester 0 has an operation pending.
REQ-006 The block SHALL have req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-007 The block SHALL have req0_a, req0_b  input  WIDTH  requester 0 operands.
REQ-008 The block SHALL have req0_func  input  FUNC_W  requester 0 function code.
REQ-009 The block SHALL have req1_valid, req1_ready, req1_a, req1_b, req1_func with the same directions, widths and meanings for requester 1.
REQ-010 The block SHALL have alu_a, alu_b  output  WIDTH  operands driven to the shared ALU instance.
REQ-011 The block SHALL have alu_func  output  FUNC_W  function code driven to the shared ALU.
REQ-012 The block SHALL have alu_result  input  WIDTH  combinational result from the shared ALU.
REQ-013 The block SHALL have rsp_valid  output  1  response register holds a result.
REQ-014 The block SHALL have rsp_ready  input  1  consumer takes the response this cycle.
REQ-015 The block SHALL have rsp_id  output  1  requester that issued the held result.
REQ-016 The block SHALL have rsp_data  output  WIDTH  registered ALU result.
REQ-017 The block SHALL have rsp_err  output  1  held result came from an undefined func (ALU default, 32'hDEADDEAD).

Function
REQ-018 Handshake: a request transfers when reqN_valid && reqN_ready at a rising edge; a response transfers when rsp_valid && rsp_ready.
REQ-019 slot_free = !rsp_valid || rsp_ready; requests are granted only when slot_free is high.
REQ-020 With slot_free high and one requester valid, that requester gets ready=1.
REQ-021 With slot_free high and both valid, grant goes to the requester not granted last (round-robin pointer last_grant); last_grant updates only on an accepted transfer.
REQ-022 At most one reqN_ready is high per cycle; reqN_ready is combinational from the valids, slot_free and last_grant, and is never high while slot_free is low.
REQ-023 alu_a/alu_b/alu_func mux the granted requester's fields; with no grant they carry requester last_grant^1 fields (don't-care), never X after reset.
REQ-024 Latency: request accepted at edge N -> rsp_valid=1, rsp_data=alu_result, rsp_id=grant, rsp_err=(func not a defined ALU_* code) after edge N.
REQ-025 Simultaneous drain and accept: old response leaves and the new one loads at the same edge, sustaining 1 op/cycle with no bubble.
REQ-026 Backpressure: rsp_valid=1 and rsp_ready=0 -> rsp_data/rsp_id/rsp_err hold, both readies stay 0.
REQ-027 Drain without a new accept -> rsp_valid falls to 0 at that edge.
REQ-028 Fairness: with both requesters continuously valid and rsp_ready=1, grants strictly alternate; no requester waits more than one accepted transfer.
REQ-029 A valid request that drops before it is granted is discarded with no state change; the block does not require requesters to hold valid.

Reset
REQ-030 When rst=1 at a rising edge: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, last_grant=1 (requester 0 wins the first tie).
REQ-031 While rst=1, req0_ready and req1_ready SHALL be 0; reset mid-operation drops any held response without it transferring.

Verification
REQ-032 Only req0 valid, ADD 0x12345678+0x87654321, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_data=0x99999999, rsp_err=0.
REQ-033 Both valid every cycle (req0 SUB 5-3, req1 XOR 0xF0F0F0F0^0x0F0F0F0F), rsp_ready=1 -> responses id 0,1,0,1: data 0x2, 0xFFFFFFFF alternating, one per cycle.
REQ-034 Response pending with rsp_ready=0 for 3 cycles, both requesters valid -> both readies 0, rsp_data held; rsp_ready=1 -> drain and accept in the same cycle.
REQ-035 req1 func=4'b1111 -> rsp_data=0xDEADDEAD, rsp_err=1, rsp_id=1.
REQ-036 rst asserted while rsp_valid=1 and rsp_ready=0 -> next cycle rsp_valid=0, readies 0; after release the first tie goes to requester 0.
